systolic_ctrl: RTL and testbench
================================

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 12: idle cycles after the last row so the array can flush.
REQ-002 Parameter ADDR_W, default 8: width of the sample-buffer address.
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 cmd_valid  input  1  host requests one block run.
REQ-006 cmd_ready  output  1  controller can accept a command.
REQ-007 cmd_base  input  ADDR_W  buffer address of row 0.
REQ-008 cmd_rows  input  4  number of rows N (0..15).
REQ-009 abort  input  1  terminate the current run.
REQ-010 mem_rd_en  output  1  sample-buffer read strobe.
REQ-011 mem_addr  output  ADDR_W  sample-buffer read address.
REQ-012 mem_rd_data  input  128  row data, 1-cycle read latency; lanes [31:0],[63:32],[95:64],[127:96] = columns 1..4.
REQ-013 sa_start  output  1  start pulse to the array.
REQ-014 sa_x01, sa_x02, sa_x03, sa_x04  output  32 each  array column inputs.
REQ-015 busy  output  1  run in progress.
REQ-016 done  output  1  one-cycle run-complete pulse.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, STREAM, DRAIN and DONE.
REQ-018 cmd_ready SHALL be 1 only in IDLE; the command is accepted on the edge ending cycle k where cmd_valid=1 and cmd_ready=1; cmd_base and cmd_rows are latched on that edge.
REQ-019 For N>=1, mem_rd_en SHALL be 1 in cycles k+1..k+N, with mem_addr = cmd_base+i in cycle k+1+i; the address sum wraps modulo 2^ADDR_W.
REQ-020 The data returned for read i SHALL be registered onto sa_x01..sa_x04 in cycle k+3+i and held exactly one cycle.
REQ-021 sa_start SHALL be 1 in cycle k+3 only, coincident with row 0.
REQ-022 Outside the row cycles, sa_x01..sa_x04 SHALL be 0 and mem_addr SHALL be 0 whenever mem_rd_en=0.
REQ-023 DRAIN SHALL last exactly DRAIN_CYCLES cycles, starting in cycle k+3+N.
REQ-024 done SHALL be 1 in cycle k+3+N+DRAIN_CYCLES; the FSM then returns to IDLE, so cmd_ready=1 in the following cycle.
REQ-025 busy SHALL be 1 from cycle k+1 through the done cycle inclusive, and 0 otherwise.
REQ-026 For N=0, the controller SHALL issue no reads and no sa_start, and SHALL assert done and busy in cycle k+1 only.
REQ-027 cmd_valid while busy SHALL be ignored (not queued).
REQ-028 abort=1 in any non-IDLE cycle SHALL return the FSM to IDLE on the next edge.
REQ-029 An aborted run SHALL produce no done; from that edge, mem_rd_en, sa_start and sa_x* are 0, and any in-flight read data is discarded.
REQ-030 abort in IDLE SHALL have no effect.
REQ-031 If abort and done would coincide, done SHALL win and the run completes normally.
REQ-032 A row counter SHALL track rows issued; it SHALL saturate at N and wrap nowhere else.
REQ-033 mem_rd_data SHALL be sampled only in the cycle after a read strobe.

Reset
REQ-034 While rst=0 at a rising edge, the FSM SHALL enter IDLE and all counters and latched command fields SHALL clear.
REQ-035 The reset values of the outputs SHALL be: cmd_ready=1; mem_rd_en=0; mem_addr=0; sa_start=0; sa_x*=0; busy=0; done=0.
REQ-036 Reset mid-run SHALL behave like abort, but also clear latched command fields; no done is produced.
REQ-037 The first command SHALL be accepted in the first cycle after rst returns to 1.

Verification
REQ-038 Nominal run: base=0x10, N=10, DRAIN_CYCLES=12, with buffer row i lanes = {4i+3,4i+2,4i+1,4i} -> reads at 0x10..0x19 in cycles k+1..k+10; sa_start only at k+3; sa_x01=4i at k+3+i; done at k+25; busy k+1..k+25.
REQ-039 Address wrap: base=0xFE, N=4 -> mem_addr 0xFE, 0xFF, 0x00, 0x01; the rows stream in that order.
REQ-040 Zero rows: N=0 -> no mem_rd_en and no sa_start; done=busy=1 at k+1 only; cmd_ready=1 at k+2.
REQ-041 Abort: N=10, abort at k+6 -> from k+7, all outputs are 0 and cmd_ready=1; no done ever appears; a new command at k+7 runs normally.
REQ-042 Command while busy: cmd_valid held through a run -> exactly one run completes, then a second run is accepted in the cycle after done.
REQ-043 Reset mid-run: rst=0 during STREAM -> the next cycle shows the REQ-035 values; no done is produced.

Source files
------------

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: accepts a host block command, fetches N rows from the sample buffer,
// streams them onto the four array columns, drains the array and pulses done.

module systolic_lane #(
  parameter int VEC_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [VEC_W-1:0] din,
  output logic [VEC_W-1:0] dout
);
  // Column register holds a row for exactly one cycle; zero otherwise.
  always_ff @(posedge clk) begin
    dout <= (load && !clr) ? din : '0;
  end
endmodule

module systolic_ctrl #(
  parameter int DRAIN_CYCLES = 12,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [3:0]        cmd_rows,
  input  logic              abort,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [127:0]      mem_rd_data,
  output logic              sa_start,
  output logic [31:0]       sa_x01,
  output logic [31:0]       sa_x02,
  output logic [31:0]       sa_x03,
  output logic [31:0]       sa_x04,
  output logic              busy,
  output logic              done
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 32;
  localparam int STAGES    = 1;
  localparam int CNT_W     = $clog2(DRAIN_CYCLES + 2) + 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, STREAM, DRAIN, DONE} state_t;

  state_t                              state, state_nxt;
  logic [ADDR_W-1:0]                   base_q;
  logic [3:0]                          rows_q;
  logic [3:0]                          row_cnt;
  logic [CNT_W-1:0]                    cnt;
  logic [STAGES:0]                     vld_pipe;
  logic [STAGES:0]                     first_pipe;
  logic                                kill;
  logic                                lane_clr;
  logic [NUM_LANES-1:0][VEC_W-1:0]     lane_din;
  logic [NUM_LANES-1:0][VEC_W-1:0]     lane_dout;

  // Abort only bites while a run is active; in DONE the completion takes priority.
  assign kill = abort && (state == FETCH || state == STREAM || state == DRAIN);

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nxt = (cmd_rows == 4'd0) ? DONE : FETCH;
      end
      FETCH: begin
        mem_rd_en = 1'b1;
        if (row_cnt == rows_q - 4'd1) state_nxt = STREAM;
      end
      // Two cycles let the last read return and land on the column registers.
      STREAM: if (cnt == CNT_W'(1)) state_nxt = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
      DRAIN:  if (cnt == DRAIN_LAST) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  assign mem_addr = mem_rd_en ? base_q + ADDR_W'(row_cnt) : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      base_q     <= '0;
      rows_q     <= '0;
      row_cnt    <= '0;
      cnt        <= '0;
      vld_pipe   <= '0;
      first_pipe <= '0;
    end else begin
      state <= state_nxt;
      if (cmd_ready && cmd_valid) begin
        base_q  <= cmd_base;
        rows_q  <= cmd_rows;
        row_cnt <= '0;
      end else if (mem_rd_en && row_cnt != rows_q) begin
        row_cnt <= row_cnt + 4'd1;
      end
      if (state_nxt != state)                 cnt <= '0;
      else if (state == STREAM || state == DRAIN) cnt <= cnt + 1'b1;
      // Read-data alignment: bit 0 = data on mem_rd_data, bit STAGES = row on columns.
      if (kill) begin
        vld_pipe   <= '0;
        first_pipe <= '0;
      end else begin
        vld_pipe   <= {vld_pipe[STAGES-1:0], mem_rd_en};
        first_pipe <= {first_pipe[STAGES-1:0], mem_rd_en && row_cnt == 4'd0};
      end
    end
  end

  assign lane_din = mem_rd_data;
  assign lane_clr = !rst || kill;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      systolic_lane #(.VEC_W(VEC_W)) u_lane (
        .clk  (clk),
        .clr  (lane_clr),
        .load (vld_pipe[0]),
        .din  (lane_din[g]),
        .dout (lane_dout[g])
      );
    end
  endgenerate

  assign sa_start = first_pipe[STAGES];
  assign sa_x01   = lane_dout[0];
  assign sa_x02   = lane_dout[1];
  assign sa_x03   = lane_dout[2];
  assign sa_x04   = lane_dout[3];

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl: a cycle-indexed run model predicts reads, rows,
// done and busy windows; a negedge monitor pops and compares against the DUT.
module tb_systolic_ctrl;
  localparam int D  = 12;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base = '0;
  logic [3:0]    cmd_rows = '0;
  logic          abort = 1'b0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [127:0]  mem_rd_data = '0;
  logic          sa_start;
  logic [31:0]   sa_x01, sa_x02, sa_x03, sa_x04;
  logic          busy;
  logic          done;

  systolic_ctrl #(.DRAIN_CYCLES(D), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_rows(cmd_rows), .abort(abort),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .sa_start(sa_start), .sa_x01(sa_x01), .sa_x02(sa_x02), .sa_x03(sa_x03),
    .sa_x04(sa_x04), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Sample buffer: one-cycle latency, garbage on the bus when no read was issued.
  logic [127:0] mem [256];
  always @(posedge clk)
    mem_rd_data <= mem_rd_en ? mem[mem_addr] : {$urandom, $urandom, $urandom, $urandom};

  typedef struct { int cyc; logic [7:0] addr; } rd_t;
  typedef struct { int cyc; logic [127:0] data; logic first; } row_t;
  rd_t  rd_q[$];
  row_t row_q[$];
  int   done_q[$];
  int   cyc = 0;
  int   run_beg = -10;
  int   run_end = -10;
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;

  function automatic bit active(int c);
    return (c >= run_beg) && (c <= run_end);
  endfunction

  function automatic void flush_after(int c);
    while (rd_q.size() > 0 && rd_q[rd_q.size()-1].cyc > c) void'(rd_q.pop_back());
    while (row_q.size() > 0 && row_q[row_q.size()-1].cyc > c) void'(row_q.pop_back());
    while (done_q.size() > 0 && done_q[done_q.size()-1] > c) void'(done_q.pop_back());
  endfunction

  // Evaluated at the edge that ends cycle `cyc`, using that cycle's inputs.
  task automatic model_step();
    int c;
    logic [7:0] a;
    c = cyc;
    if (!rst) begin
      if (active(c)) begin flush_after(c); run_end = c; end
    end else if (abort && active(c) && c != run_end) begin
      flush_after(c);
      run_end = c;
    end else if (cmd_valid && !active(c)) begin
      run_beg = c + 1;
      if (cmd_rows == 4'd0) begin
        run_end = c + 1;
      end else begin
        for (int i = 0; i < int'(cmd_rows); i++) begin
          a = cmd_base + 8'(i);
          rd_q.push_back('{c + 1 + i, a});
          row_q.push_back('{c + 3 + i, mem[a], (i == 0)});
        end
        run_end = c + 3 + int'(cmd_rows) + D;
      end
      done_q.push_back(run_end);
    end
    cyc = cyc + 1;
  endtask

  task automatic cmp(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  task automatic monitor_step();
    bit   b;
    rd_t  er;
    row_t ew;
    b = active(cyc);
    cmp("busy", busy, b);
    cmp("cmd_ready", cmd_ready, !b);
    if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
      er = rd_q.pop_front();
      cmp("mem_rd_en", mem_rd_en, 1'b1);
      cmp("mem_addr", mem_addr, er.addr);
    end else begin
      cmp("mem_rd_en_idle", mem_rd_en, 1'b0);
      cmp("mem_addr_idle", mem_addr, '0);
    end
    if (row_q.size() > 0 && row_q[0].cyc == cyc) begin
      ew = row_q.pop_front();
      cmp("sa_x", {sa_x04, sa_x03, sa_x02, sa_x01}, ew.data);
      cmp("sa_start", sa_start, ew.first);
    end else begin
      cmp("sa_x_idle", {sa_x04, sa_x03, sa_x02, sa_x01}, '0);
      cmp("sa_start_idle", sa_start, 1'b0);
    end
    if (done_q.size() > 0 && done_q[0] == cyc) begin
      void'(done_q.pop_front());
      cmp("done", done, 1'b1);
    end else begin
      cmp("done_idle", done, 1'b0);
    end
  endtask

  initial forever begin @(posedge clk); model_step(); end
  initial forever begin @(negedge clk); if (chk_en) monitor_step(); end

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (active(cyc) && guard < 400) begin tick(); guard++; end
    if (guard >= 400) begin
      checks++; failures++;
      $display("FAIL wait_idle cyc=%0d got=busy want=idle", cyc);
    end
  endtask

  task automatic issue(input logic [7:0] b, input logic [3:0] n);
    wait_idle();
    cmd_valid = 1'b1; cmd_base = b; cmd_rows = n;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 10; i++)
      mem[8'h10 + i] = {32'(4*i+3), 32'(4*i+2), 32'(4*i+1), 32'(4*i)};
    @(posedge clk); #1;
    chk_en = 1'b1;
    tick(); tick();
    rst = 1'b1;
    // Nominal run issued in the first cycle out of reset.
    issue(8'h10, 4'd10); wait_idle();
    issue(8'hFE, 4'd4);  wait_idle();
    issue(8'h33, 4'd0);  wait_idle();
    // Abort at k+6, then a fresh command at k+7.
    issue(8'h20, 4'd10);
    repeat (5) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    issue(8'h40, 4'd3); wait_idle();
    // Abort landing on the done cycle (k+3+1+D) must not suppress done.
    issue(8'h50, 4'd1);
    repeat (3 + 1 + D - 1) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    wait_idle();
    // Command held across runs.
    cmd_valid = 1'b1; cmd_base = 8'h60; cmd_rows = 4'd2;
    repeat (2 * (3 + 2 + D) + 10) tick();
    cmd_valid = 1'b0;
    wait_idle();
    // Reset in the middle of a run, then an immediate new command.
    issue(8'h70, 4'd8);
    repeat (4) tick();
    rst = 1'b0; tick(); rst = 1'b1;
    issue(8'h80, 4'd2); wait_idle();
    // Randomized traffic.
    for (int t = 0; t < 3000; t++) begin
      if (!active(cyc) && $urandom_range(0, 4) == 0)
        mem[$urandom_range(0, 255)] = {$urandom, $urandom, $urandom, $urandom};
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_base  = 8'($urandom);
      cmd_rows  = 4'($urandom);
      abort     = ($urandom_range(0, 99) < 2);
      rst       = !($urandom_range(0, 299) == 0);
      tick();
    end
    cmd_valid = 1'b0; abort = 1'b0; rst = 1'b1;
    wait_idle();
    repeat (5) tick();
    cmp("queues_empty", 128'(rd_q.size() + row_q.size() + done_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
